// File: rtl/table_seq_gen_if.sv
// Handshake bundle for the multiplication-table sequencer: start/operand request
// side plus the valid/ready product stream and status flags.
interface table_seq_gen_if #(
    parameter int WIDTH = 10,
    parameter int IDX_W = 4,
    parameter int OUT_W = 14
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [IDX_W-1:0] terms;
    logic             abort;
    logic             out_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic [IDX_W-1:0] out_idx;
    logic             busy;
    logic             done;
    logic             ovf;

    modport master (
        output start, a, terms, abort, out_ready,
        input  out_valid, out_data, out_idx, busy, done, ovf
    );

    modport slave (
        input  start, a, terms, abort, out_ready,
        output out_valid, out_data, out_idx, busy, done, ovf
    );
endinterface

// File: rtl/table_seq_gen.sv
// Streams a*1 .. a*N on a valid/ready port, building each product by saturating
// repeated addition; one-cycle done pulse on normal completion.
module table_seq_gen #(
    parameter int WIDTH = 10,
    parameter int IDX_W = 4,
    parameter int OUT_W = 14
) (
    input  logic           clk,
    input  logic           rst,
    table_seq_gen_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Wide enough to hold any accumulator + operand sum without wrapping.
    localparam int SUM_W = ((OUT_W > WIDTH) ? OUT_W : WIDTH) + 2;
    localparam logic [SUM_W-1:0] MAX_SUM = {{(SUM_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    function automatic logic over_max(input logic [SUM_W-1:0] v);
        return (v > MAX_SUM);
    endfunction

    function automatic logic [OUT_W:0] sat_clamp(input logic [SUM_W-1:0] v);
        logic [SUM_W-1:0] c;
        c = (v > MAX_SUM) ? MAX_SUM : v;
        return c[OUT_W:0];
    endfunction

    logic [1:0]       state_q, state_d;
    logic [OUT_W:0]   acc_q,   acc_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [IDX_W-1:0] n_q,     n_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             valid_q, valid_d;
    logic             ovf_q,   ovf_d;

    logic [SUM_W-1:0] load_sum;
    logic [SUM_W-1:0] step_sum;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        a_d      = a_q;
        n_d      = n_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        load_sum = SUM_W'(bus.a);
        step_sum = SUM_W'(acc_q) + SUM_W'(a_q);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    ovf_d = 1'b0;
                    if (bus.terms != '0) begin
                        // An operand wider than the output already saturates on beat 1.
                        a_d     = bus.a;
                        n_d     = bus.terms;
                        acc_d   = sat_clamp(load_sum);
                        ovf_d   = over_max(load_sum);
                        idx_d   = IDX_W'(1);
                        valid_d = 1'b1;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end else if (valid_q && bus.out_ready) begin
                    if (idx_q == n_q) begin
                        valid_d = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        acc_d = sat_clamp(step_sum);
                        if (over_max(step_sum)) begin
                            ovf_d = 1'b1;
                        end
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            a_q     <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = acc_q[OUT_W-1:0];
    assign bus.out_idx   = idx_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_table_seq_gen.sv
// Directed bench for table_seq_gen: a default-width instance and an OUT_W=8
// instance, checked against hand-computed product sequences.
module tb_table_seq_gen;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    table_seq_gen_if bus14 ();
    table_seq_gen_if #(.OUT_W(8)) bus8 ();

    table_seq_gen u_dut14 (.clk(clk), .rst(rst), .bus(bus14));
    table_seq_gen #(.OUT_W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat;
        int         k;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus14.start = 0; bus14.a = '0; bus14.terms = '0; bus14.abort = 0; bus14.out_ready = 1;
        bus8.start  = 0; bus8.a  = '0; bus8.terms  = '0; bus8.abort  = 0; bus8.out_ready  = 1;
        #12;
        check("rst_valid", bus14.out_valid, 0);
        check("rst_data",  bus14.out_data,  0);
        check("rst_idx",   bus14.out_idx,   0);
        check("rst_busy",  bus14.busy,      0);
        check("rst_done",  bus14.done,      0);
        check("rst_ovf",   bus14.ovf,       0);
        tick;
        rst = 1'b0;
        tick;

        // a=2, N=10, ready high: one beat per cycle
        bus14.a = 10'd2; bus14.terms = 4'd10; bus14.start = 1;
        tick;
        bus14.start = 0;
        for (int i = 1; i <= 10; i++) begin
            check("t1_valid", bus14.out_valid, 1);
            check("t1_data",  bus14.out_data,  2 * i);
            check("t1_idx",   bus14.out_idx,   i);
            check("t1_done",  bus14.done,      0);
            tick;
        end
        check("t1_valid_end", bus14.out_valid, 0);
        check("t1_done_p",    bus14.done,      1);
        check("t1_busy_p",    bus14.busy,      1);
        check("t1_ovf",       bus14.ovf,       0);
        tick;
        check("t1_done_off",  bus14.done,      0);
        check("t1_busy_off",  bus14.busy,      0);
        check("t1_data_hold", bus14.out_data,  20);
        check("t1_idx_hold",  bus14.out_idx,   10);

        // a=7, N=5 with stalls
        bus14.a = 10'd7; bus14.terms = 4'd5; bus14.start = 1;
        tick;
        bus14.start = 0;
        pat = 4'b1001;
        k = 1;
        for (int c = 0; c < 40 && k <= 5; c++) begin
            bus14.out_ready = pat[c % 4];
            check("t2_valid", bus14.out_valid, 1);
            check("t2_data",  bus14.out_data,  7 * k);
            check("t2_idx",   bus14.out_idx,   k);
            check("t2_done",  bus14.done,      0);
            tick;
            if (pat[c % 4]) k++;
        end
        check("t2_count", k, 6);
        check("t2_valid_end", bus14.out_valid, 0);
        check("t2_done_p",    bus14.done,      1);
        bus14.out_ready = 1;
        tick;

        // OUT_W=8: a=100, N=4 saturates from beat 3
        bus8.a = 10'd100; bus8.terms = 4'd4; bus8.start = 1;
        tick;
        bus8.start = 0;
        check("t3_d1", bus8.out_data, 100); check("t3_o1", bus8.ovf, 0); tick;
        check("t3_d2", bus8.out_data, 200); check("t3_o2", bus8.ovf, 0); tick;
        check("t3_d3", bus8.out_data, 255); check("t3_o3", bus8.ovf, 1); tick;
        check("t3_d4", bus8.out_data, 255); check("t3_i4", bus8.out_idx, 4);
        check("t3_o4", bus8.ovf, 1); tick;
        check("t3_done", bus8.done, 1); check("t3_ovf_done", bus8.ovf, 1); tick;
        check("t3_ovf_idle", bus8.ovf, 1);
        bus8.a = 10'd1; bus8.terms = 4'd2; bus8.start = 1;
        tick;
        bus8.start = 0;
        check("t3b_ovf", bus8.ovf, 0);
        check("t3b_d1", bus8.out_data, 1); check("t3b_i1", bus8.out_idx, 1); tick;
        check("t3b_d2", bus8.out_data, 2); check("t3b_i2", bus8.out_idx, 2); tick;
        check("t3b_done", bus8.done, 1);
        tick;

        // a=3, N=8, abort after the third handshake
        bus14.a = 10'd3; bus14.terms = 4'd8; bus14.start = 1;
        tick;
        bus14.start = 0;
        check("t4_d1", bus14.out_data, 3); tick;
        check("t4_d2", bus14.out_data, 6); tick;
        check("t4_d3", bus14.out_data, 9); tick;
        check("t4_d4", bus14.out_data, 12);
        bus14.abort = 1;
        tick;
        bus14.abort = 0;
        check("t4_valid", bus14.out_valid, 0);
        check("t4_busy",  bus14.busy,      0);
        check("t4_done",  bus14.done,      0);
        tick;
        check("t4_done2", bus14.done,      0);
        // start and abort together in IDLE: start wins
        bus14.a = 10'd3; bus14.terms = 4'd2; bus14.start = 1; bus14.abort = 1;
        tick;
        bus14.start = 0; bus14.abort = 0;
        check("t4b_valid", bus14.out_valid, 1);
        check("t4b_idx1",  bus14.out_idx,   1);
        check("t4b_d1",    bus14.out_data,  3); tick;
        check("t4b_d2",    bus14.out_data,  6); tick;
        check("t4b_done",  bus14.done,      1);
        tick;

        // terms=0: immediate done, no beats
        bus14.a = 10'd5; bus14.terms = 4'd0; bus14.start = 1;
        tick;
        bus14.start = 0;
        check("t5_valid", bus14.out_valid, 0);
        check("t5_done",  bus14.done,      1);
        check("t5_busy",  bus14.busy,      1);
        tick;
        check("t5_done_off", bus14.done, 0);
        check("t5_busy_off", bus14.busy, 0);
        check("t5_valid2",   bus14.out_valid, 0);

        // a=0: N beats of zero
        bus14.a = 10'd0; bus14.terms = 4'd2; bus14.start = 1;
        tick;
        bus14.start = 0;
        check("t7_v1", bus14.out_valid, 1); check("t7_d1", bus14.out_data, 0); tick;
        check("t7_i2", bus14.out_idx, 2);   check("t7_d2", bus14.out_data, 0); tick;
        check("t7_done", bus14.done, 1);
        tick;

        // start during RUN ignored, then async reset between edges
        bus14.a = 10'd5; bus14.terms = 4'd6; bus14.start = 1;
        tick;
        check("t6_d1", bus14.out_data, 5);
        bus14.a = 10'd9; bus14.terms = 4'd1;
        tick;
        bus14.start = 0;
        check("t6_d2", bus14.out_data, 10);
        check("t6_i2", bus14.out_idx,  2);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", bus14.out_valid, 0);
        check("t6_rst_data",  bus14.out_data,  0);
        check("t6_rst_idx",   bus14.out_idx,   0);
        check("t6_rst_busy",  bus14.busy,      0);
        check("t6_rst_ovf",   bus14.ovf,       0);
        tick;
        rst = 1'b0;
        tick;
        check("t6_idle_valid", bus14.out_valid, 0);
        check("t6_idle_busy",  bus14.busy,      0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/table_seq_gen.md
Name: table_seq_gen

Overview:
- Parametrised multiplication-table sequencer, successor to the free-running table counter.
- On a start request it latches an operand `a` and a term count N. It then streams `a*1, a*2, ... a*N`, one product per accepted beat, on a valid/ready output port.
- Products are formed by repeated addition (no multiplier). Out-of-range results saturate. Completion is signalled with a one-cycle done pulse.
- Used as a stimulus/lookup source feeding downstream arithmetic blocks in the Mathematical_concepts set.

Parameters:
- WIDTH, 10, operand width of `a`.
- IDX_W, 4, width of term count and index; maximum N = 2^IDX_W-1.
- OUT_W, 14, width of the product output; results above 2^OUT_W-1 saturate.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new table; honoured only in IDLE.
- a  input  WIDTH  operand; sampled on the accepted start cycle.
- terms  input  IDX_W  term count N; sampled on the accepted start cycle.
- abort  input  1  cancel a run in progress.
- out_ready  input  1  downstream accepts the current beat.
- out_valid  output  1  out_data/out_idx hold a valid product.
- out_data  output  OUT_W  product a*out_idx, saturated.
- out_idx  output  IDX_W  current multiplier index (1..N).
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse at normal completion.
- ovf  output  1  sticky: some product in this run saturated.

Behaviour:
- Reset (async, any state, mid-run included): state=IDLE; out_valid, out_data, out_idx, busy, done, ovf all 0; internal accumulator 0. Takes effect immediately, not at the next edge.
- States: IDLE, RUN, DONE.
- IDLE, start=1 with terms!=0:
  - latch a; latch N=terms; accumulator=a; idx=1; ovf cleared.
  - -> RUN. out_valid=1 on the next cycle, so latency is 1 cycle from start to first beat.
- IDLE, start=1 with terms==0: latch nothing visible; ovf cleared; -> DONE. No beats are produced.
- RUN:
  - out_data = min(acc, 2^OUT_W-1); out_idx = idx; out_valid=1.
  - Accumulator is OUT_W+1 bits. If the sum would exceed 2^OUT_W-1, the accumulator clamps at 2^OUT_W-1 and ovf is set.
  - out_data/out_idx stay stable while out_valid=1 and out_ready=0 (stall).
  - Handshake (out_valid & out_ready) with idx<N: acc<=acc+a (saturating); idx<=idx+1; out_valid stays 1. Back-to-back beats are allowed, one per cycle.
  - Handshake with idx==N: out_valid<=0; -> DONE.
  - abort=1 in RUN (has priority over the handshake): out_valid<=0; -> IDLE. No done pulse. ovf holds its value.
- DONE: done=1 for exactly one cycle, then -> IDLE. abort is ignored in DONE.
- busy is 1 in RUN and DONE, 0 in IDLE.
- start is ignored outside IDLE; a/terms changes there have no effect.
- start and abort both high in IDLE: start wins, abort is ignored.
- a=0: normal run producing N beats of 0.
- ovf and the last out_data/out_idx persist in IDLE until the next accepted start.
- Throughput: N beats in N cycles with out_ready held high. Total from start to done = N+2 cycles.

Test Plan:
- Default params, a=2, terms=10, out_ready=1, start for 1 cycle -> out_valid from next cycle, out_data 2,4,...,20 with out_idx 1..10 on consecutive cycles; done pulses once the cycle after beat 10; ovf=0.
- a=7, terms=5, out_ready toggled 1,0,0,1,... -> data held stable during stalls; sequence 7,14,21,28,35 exactly once each; no beat dropped or duplicated.
- OUT_W=8 instance, a=100, terms=4 -> out_data 100,200,255,255; ovf rises on beat 3 and stays 1 after done; next start with a=1, terms=2 clears ovf and gives 1,2.
- a=3, terms=8, abort asserted after 3rd handshake -> out_valid low next cycle, no done pulse, busy=0; a new start then runs cleanly from idx=1.
- terms=0 with start -> no out_valid, done pulse 1 cycle later, busy high only that cycle.
- Assert rst asynchronously mid-run (between edges) with out_valid=1 -> all outputs 0 immediately; start pulsed during RUN (not after rst) is ignored.
